// File: rtl/i2s_track_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : i2s_track_scheduler
// Purpose  : Once per stereo frame (rising edge of ws) polls NUM_TRACKS track
//            sources in index order with a one-cycle ready/valid handshake,
//            sums the accepted samples with signed saturation and presents the
//            mix on tx_data_l/tx_data_r. Tracks per-track underruns and late
//            frame starts as sticky status.
// Options  : UNDERRUN_HOLD_EN - when defined, an underrunning enabled track
//            repeats its last accepted sample instead of contributing silence.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_track_scheduler #(
  parameter int WIDTH      = 16,
  parameter int NUM_TRACKS = 4
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic                          ws,
  input  logic [NUM_TRACKS-1:0]         trk_enable,
  input  logic [NUM_TRACKS-1:0]         trk_valid,
  input  logic [NUM_TRACKS*WIDTH-1:0]   trk_data_l,
  input  logic [NUM_TRACKS*WIDTH-1:0]   trk_data_r,
  output logic [NUM_TRACKS-1:0]         trk_ready,
  input  logic                          clr_status,
  output logic [WIDTH-1:0]              tx_data_l,
  output logic [WIDTH-1:0]              tx_data_r,
  output logic                          frame_done,
  output logic                          busy,
  output logic [NUM_TRACKS-1:0]         underrun,
  output logic                          frame_overrun
);

  localparam int c_idx_w = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
  // One guard bit beyond the worst-case growth of the sum.
  localparam int c_acc_w = WIDTH + $clog2(NUM_TRACKS) + 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_TRACKS - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
  localparam logic signed [c_acc_w-1:0] c_sat_max =
    {{(c_acc_w-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [c_acc_w-1:0] c_sat_min =
    {{(c_acc_w-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [c_idx_w-1:0]          r_idx;
  logic [c_idx_w-1:0]          w_idx_nxt;
  logic [NUM_TRACKS-1:0]       w_ready;

  logic                        r_ws_q;
  logic                        r_ws_armed;
  logic                        w_frame_start;

  logic signed [WIDTH-1:0]     w_trk_l [NUM_TRACKS];
  logic signed [WIDTH-1:0]     w_trk_r [NUM_TRACKS];
  logic signed [WIDTH-1:0]     w_cur_l;
  logic signed [WIDTH-1:0]     w_cur_r;
  logic                        w_fetch;
  logic                        w_take;
  logic                        w_miss;
  logic signed [WIDTH-1:0]     w_add_l;
  logic signed [WIDTH-1:0]     w_add_r;
  logic [NUM_TRACKS-1:0]       w_urun_set;

  logic signed [c_acc_w-1:0]   r_acc_l;
  logic signed [c_acc_w-1:0]   r_acc_r;
  logic [WIDTH-1:0]            r_tx_l;
  logic [WIDTH-1:0]            r_tx_r;
  logic                        r_frame_done;
  logic [NUM_TRACKS-1:0]       r_underrun;
  logic                        r_overrun;

  // Split the packed sample buses into per-track words.
  for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_unpack
    assign w_trk_l[g] = trk_data_l[g*WIDTH +: WIDTH];
    assign w_trk_r[g] = trk_data_r[g*WIDTH +: WIDTH];
  end

  // A ws already high when reset releases must go low before it can start a
  // frame, so the edge detector is armed only after ws has been seen low.
  assign w_frame_start = ws & ~r_ws_q & r_ws_armed;
  assign busy          = (r_state != S_IDLE);
  assign w_fetch       = (r_state == S_FETCH);
  assign w_cur_l       = w_trk_l[r_idx];
  assign w_cur_r       = w_trk_r[r_idx];
  assign w_take        = w_fetch & trk_enable[r_idx] & trk_valid[r_idx];
  assign w_miss        = w_fetch & trk_enable[r_idx] & ~trk_valid[r_idx];

  assign trk_ready     = w_ready;
  assign tx_data_l     = r_tx_l;
  assign tx_data_r     = r_tx_r;
  assign frame_done    = r_frame_done;
  assign underrun      = r_underrun;
  assign frame_overrun = r_overrun;

  function automatic logic [WIDTH-1:0] f_sat(input logic signed [c_acc_w-1:0] a);
    if (a > c_sat_max) begin
      return c_sat_max[WIDTH-1:0];
    end else if (a < c_sat_min) begin
      return c_sat_min[WIDTH-1:0];
    end
    return a[WIDTH-1:0];
  endfunction

  // Word-select edge detector and its post-reset arming flag.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_ws_q     <= 1'b0;
      r_ws_armed <= 1'b0;
    end else begin
      r_ws_q <= ws;
      if (!ws) begin
        r_ws_armed <= 1'b1;
      end
    end
  end

  // FSM state and poll index registers.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic and the one-hot poll strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_frame_start) begin
          w_state_nxt = S_FETCH;
          w_idx_nxt   = '0;
        end
      end
      S_FETCH: begin
        w_ready[r_idx] = trk_enable[r_idx];
        if (r_idx == c_last_idx) begin
          w_state_nxt = S_COMMIT;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + c_idx_one;
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

`ifdef UNDERRUN_HOLD_EN
  logic signed [WIDTH-1:0] r_hold_l [NUM_TRACKS];
  logic signed [WIDTH-1:0] r_hold_r [NUM_TRACKS];

  // Remember each track's last accepted sample for underrun concealment.
  always_ff @(posedge mclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TRACKS; i++) begin
        r_hold_l[i] <= '0;
        r_hold_r[i] <= '0;
      end
    end else if (w_take) begin
      r_hold_l[r_idx] <= w_cur_l;
      r_hold_r[r_idx] <= w_cur_r;
    end
  end

  // Contribution of the polled track: fresh sample, held sample or silence.
  always_comb begin
    w_add_l = '0;
    w_add_r = '0;
    if (w_take) begin
      w_add_l = w_cur_l;
      w_add_r = w_cur_r;
    end else if (w_miss) begin
      w_add_l = r_hold_l[r_idx];
      w_add_r = r_hold_r[r_idx];
    end
  end
`else
  // Contribution of the polled track: fresh sample or silence.
  always_comb begin
    w_add_l = '0;
    w_add_r = '0;
    if (w_take) begin
      w_add_l = w_cur_l;
      w_add_r = w_cur_r;
    end
  end
`endif

  // Underrun event for the track currently being polled.
  always_comb begin
    w_urun_set = '0;
    if (w_miss) begin
      w_urun_set[r_idx] = 1'b1;
    end
  end

  // Mix accumulation, saturating commit and completion pulse.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_acc_l      <= '0;
      r_acc_r      <= '0;
      r_tx_l       <= '0;
      r_tx_r       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == S_COMMIT);
      case (r_state)
        S_FETCH: begin
          r_acc_l <= r_acc_l + {{(c_acc_w-WIDTH){w_add_l[WIDTH-1]}}, w_add_l};
          r_acc_r <= r_acc_r + {{(c_acc_w-WIDTH){w_add_r[WIDTH-1]}}, w_add_r};
        end
        S_COMMIT: begin
          r_tx_l <= f_sat(r_acc_l);
          r_tx_r <= f_sat(r_acc_r);
        end
        default: begin
          r_acc_l <= '0;
          r_acc_r <= '0;
        end
      endcase
    end
  end

  // Sticky status; a new event in the same cycle as a clear survives it.
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_underrun <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_underrun <= (clr_status ? '0 : r_underrun) | w_urun_set;
      r_overrun  <= (clr_status ? 1'b0 : r_overrun) | (w_frame_start & busy);
    end
  end

endmodule
`default_nettype wire

// File: doc/i2s_track_scheduler.md
# i2s_track_scheduler

Per-frame playback scheduler feeding the I2S transmitter. Once per stereo frame, on the rising edge of the transmitter's `ws`, it polls NUM_TRACKS track sources in fixed index order using a one-cycle ready/valid handshake. It sums the accepted left and right samples with signed saturation and registers the result on `tx_data_l`/`tx_data_r`, well before the transmitter's next channel load. It also tracks per-track underruns and late frame starts.

## Interface
- WIDTH, 16, signed sample width of each track and of the outputs
- NUM_TRACKS, 4, number of track sources, 1..16

- mclk  in  1  main clock
- rst  in  1  reset; synchronous, active-high; clock mclk
- ws  in  1  word-select from I2S transmitter, synchronous to mclk
- trk_enable  in  NUM_TRACKS  per-track enable, sampled in FETCH
- trk_valid  in  NUM_TRACKS  track i holds a sample for this frame
- trk_data_l  in  NUM_TRACKS*WIDTH  left samples, track i at [i*WIDTH +: WIDTH]
- trk_data_r  in  NUM_TRACKS*WIDTH  right samples, same packing
- trk_ready  out  NUM_TRACKS  one-hot poll strobe
- clr_status  in  1  clears `underrun` and `frame_overrun`
- tx_data_l  out  WIDTH  mixed left sample to transmitter
- tx_data_r  out  WIDTH  mixed right sample to transmitter
- frame_done  out  1  one-cycle pulse when new tx_data is valid
- busy  out  1  high while the FSM is not IDLE
- underrun  out  NUM_TRACKS  sticky: track was enabled but not valid when polled
- frame_overrun  out  1  sticky: ws rising edge arrived while busy

## Operation
- Frame-start detection:
  - `ws` is registered into `ws_q`.
  - frame_start = ws & ~ws_q.
- FSM states:
  - IDLE: clear accumulators. Move to FETCH with idx=0 on frame_start.
  - FETCH: `trk_ready[idx]` = trk_enable[idx]; all other ready bits are 0.
    - Transfer when ready & valid at the clock edge; add the sign-extended l/r samples to acc_l/acc_r.
    - Enabled but not valid: set underrun[idx]; the track contributes 0. No waiting.
    - Disabled: the track contributes 0 and sets no flag, but still consumes one cycle.
    - idx increments each cycle. After idx=NUM_TRACKS-1, move to COMMIT.
  - COMMIT: saturate acc_l/acc_r into tx_data_l/tx_data_r, pulse frame_done, return to IDLE.
- Arithmetic:
  - Accumulator width is WIDTH+$clog2(NUM_TRACKS)+1, signed.
  - Saturation limits are max = 2^(WIDTH-1)-1 and min = -2^(WIDTH-1).
- Late frame start: frame_start while busy is ignored and sets frame_overrun. The current frame completes normally.
- clr_status:
  - Clears both sticky flags.
  - If it coincides with a new underrun or overrun event, the set wins.
- tx_data outputs hold between commits.

## Timing
- Let edge k be the mclk edge that samples ws=1 with ws_q=0.
- trk_ready[i] is high in the cycle after edge k+i. Its transfer occurs at edge k+1+i.
- COMMIT occupies the cycle after edge k+NUM_TRACKS.
- tx_data_* update and frame_done rise at edge k+NUM_TRACKS+1. frame_done falls one cycle later.
- Latency is therefore NUM_TRACKS+1 mclk edges. With the 1536-mclk ws period this lands far inside the half-frame.
- busy is high from edge k+1 through edge k+NUM_TRACKS+1.
- Reset values: all outputs 0, FSM in IDLE, ws_q=0, accumulators 0.
- Reset mid-FETCH:
  - The frame is abandoned and trk_ready drops at the next edge.
  - tx_data returns to 0.
  - A ws already high at reset release does not generate frame_start until ws goes 0 then 1.

## Configuration
- UNDERRUN_HOLD_EN
  - Defined: each track keeps a hold register for its last accepted l/r sample (reset 0). An underrunning enabled track contributes its hold value instead of 0. Disabled tracks still contribute 0.
  - Undefined: no hold registers exist; an underrun contributes 0.
  - underrun flag behaviour is identical in both builds.

## Test plan
- 4 tracks enabled and valid, L = 100/200/-50/7, R = 1/2/3/4, ws rising edge → tx_data_l=257, tx_data_r=10, frame_done exactly 5 edges after detection, each trk_ready high exactly one cycle in order 0..3.
- All 4 tracks L=0x7000 → tx_data_l=0x7FFF. All 4 tracks L=0x9000 → tx_data_l=0x8000.
- Track 2 enabled with trk_valid=0, others L=10 → tx_data_l=30 and underrun=4'b0100. Then pulse clr_status → underrun=0.
- Track 1 disabled with valid=1, data 500 → trk_ready[1] never asserts, its sample is excluded, underrun[1] stays 0.
- Second ws rising edge injected 2 cycles after the first → frame_overrun=1, one frame_done only.
- rst asserted while idx=2 → next cycle all outputs 0 and busy=0. With UNDERRUN_HOLD_EN: track 0 sends 1234, then underruns next frame → contributes 1234.
